// File: rtl/ethernet_tx.sv
// ethernet_tx: RMII transmitter that sends one 16-bit readback word as a
// minimum-size Ethernet II frame (preamble/SFD, MAC header, padded payload,
// CRC-32 FCS) followed by an inter-frame gap.
//
// Ports:
//   clk      50 MHz RMII reference clock (only clock)
//   rst      synchronous active-high reset
//   data_i   readback data, latched on accept
//   addr_i   readback address, latched on accept (echo build only)
//   valid_i  send request, accepted when ready_o=1
//   ready_o  idle, able to accept a request
//   txen_o   RMII TX_EN
//   txd_o    RMII TXD[1:0]
//
// Build option: define ETHERNET_TX_ADDR_ECHO_EN to prefix the payload with
// addr_i (MSB byte first) ahead of data_i.
module ethernet_tx #(
  parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC   = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic [15:0] addr_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        txen_o,
  output logic [1:0]  txd_o
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_BODY,
    S_FCS,
    S_IFG
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] data_q, data_d;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
  logic [15:0] addr_q, addr_d;
`else
  logic        unused_addr;
  assign unused_addr = ^addr_i;
`endif

  logic [5:0]  byte_idx;
  logic [47:0] field_sh;
  logic [7:0]  body_byte;
  logic [7:0]  body_sh;
  logic [31:0] fcs_sh;

  // Reflected CRC-32, two bits per call, bit 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_idx = cnt_q[7:2];

  // Byte currently on the wire during BODY; header fields are shifted so the
  // wanted byte lands in bits [7:0], MSB byte of each field first.
  always_comb begin
    field_sh = '0;
    if (byte_idx < 6'd6) begin
      field_sh = DST_MAC >> {6'd5 - byte_idx, 3'b000};
    end else if (byte_idx < 6'd12) begin
      field_sh = SRC_MAC >> {6'd11 - byte_idx, 3'b000};
    end else if (byte_idx < 6'd14) begin
      field_sh = {32'h0, ETHERTYPE} >> {6'd13 - byte_idx, 3'b000};
    end else begin
      case (byte_idx)
`ifdef ETHERNET_TX_ADDR_ECHO_EN
        6'd14:   field_sh[7:0] = addr_q[15:8];
        6'd15:   field_sh[7:0] = addr_q[7:0];
        6'd16:   field_sh[7:0] = data_q[15:8];
        6'd17:   field_sh[7:0] = data_q[7:0];
`else
        6'd14:   field_sh[7:0] = data_q[15:8];
        6'd15:   field_sh[7:0] = data_q[7:0];
`endif
        default: field_sh[7:0] = 8'h00;
      endcase
    end
    body_byte = field_sh[7:0];
    body_sh   = body_byte >> {cnt_q[1:0], 1'b0};
    fcs_sh    = ~crc_q >> {cnt_q[3:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    crc_d   = crc_q;
    data_d  = data_q;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
    addr_d  = addr_q;
`endif
    txen_o  = 1'b0;
    txd_o   = 2'b00;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          state_d = S_PREAMBLE;
          data_d  = data_i;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
          addr_d  = addr_i;
`endif
        end
      end
      S_PREAMBLE: begin
        txen_o = 1'b1;
        // 31 dibits of 01 then 11: 7 x 0x55 plus SFD 0xD5, LSB dibit first.
        txd_o  = (cnt_q == 8'd31) ? 2'b11 : 2'b01;
        crc_d  = '1;
        if (cnt_q == 8'd31) begin
          state_d = S_BODY;
          cnt_d   = '0;
        end
      end
      S_BODY: begin
        txen_o = 1'b1;
        txd_o  = body_sh[1:0];
        crc_d  = crc_step(crc_q, body_sh[1:0]);
        if (cnt_q == 8'd239) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: begin
        txen_o = 1'b1;
        txd_o  = fcs_sh[1:0];
        if (cnt_q == 8'd15) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end
      end
      S_IFG: begin
        if (cnt_q == 8'd47) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_o = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '1;
      data_q  <= '0;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
      addr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
      addr_q  <= addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ethernet_tx.sv
// Testbench for ethernet_tx: a frame-level model (byte array of the whole
// frame, byte-wise CRC-32) predicts ready_o/txen_o/txd_o every cycle; a
// capture process reassembles the DUT's frames and checks length, spacing
// and the CRC residue.
module tb_ethernet_tx;

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic [15:0] addr_i;
  logic        valid_i;
  logic        ready_o;
  logic        txen_o;
  logic [1:0]  txd_o;

  ethernet_tx dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .addr_i (addr_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .txen_o (txen_o),
    .txd_o  (txd_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Whole frame as bytes: 0-7 preamble+SFD, 8-67 body, 68-71 FCS.
  task automatic build_frame(input logic [15:0] d, input logic [15:0] a,
                             output logic [7:0] fr [72]);
    logic [47:0] dst, src;
    logic [31:0] c;
    dst = 48'hFFFFFFFFFFFF;
    src = 48'h69695A065491;
    for (int i = 0; i < 72; i++) fr[i] = 8'h00;
    for (int i = 0; i < 7; i++) fr[i] = 8'h55;
    fr[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      fr[8 + i]  = dst[47 - 8*i -: 8];
      fr[14 + i] = src[47 - 8*i -: 8];
    end
    fr[20] = 8'h00;
    fr[21] = 8'h02;
`ifdef ETHERNET_TX_ADDR_ECHO_EN
    fr[22] = a[15:8];
    fr[23] = a[7:0];
    fr[24] = d[15:8];
    fr[25] = d[7:0];
`else
    fr[22] = d[15:8];
    fr[23] = d[7:0];
`endif
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) c = crc_byte(c, fr[i]);
    c = ~c;
    fr[68] = c[7:0];
    fr[69] = c[15:8];
    fr[70] = c[23:16];
    fr[71] = c[31:24];
  endtask

  // ---------------- cycle model + compare ----------------
  logic [7:0] m_frame [72];
  int         m_pos = -1;

  always @(negedge clk) begin
    logic       exp_en, exp_rdy;
    logic [1:0] exp_d;
    logic [7:0] t8;
    if (cyc >= 1) begin
      exp_en  = (m_pos >= 0) && (m_pos < 288);
      exp_rdy = (m_pos < 0);
      exp_d   = 2'b00;
      if (exp_en) begin
        t8    = m_frame[m_pos / 4] >> (2 * (m_pos % 4));
        exp_d = t8[1:0];
      end
      check("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
      check("txen_o",  {31'd0, txen_o},  {31'd0, exp_en});
      check("txd_o",   {30'd0, txd_o},   {30'd0, exp_d});
    end
    // advance model with inputs the coming posedge will sample
    if (rst) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (valid_i) begin
        build_frame(data_i, addr_i, m_frame);
        m_pos = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == 336) m_pos = -1;
    end
  end

  // ---------------- frame capture ----------------
  logic [7:0]  cap [72];
  int          run_len = 0;
  int          n_runs  = 0;
  int          n_full  = 0;
  int          n_trunc = 0;
  int          rise_t   [16];
  int          len_log  [16];
  logic [31:0] fcs_log  [16];

  always @(negedge clk) begin
    logic [31:0] r;
    if (cyc >= 1) begin
      if (txen_o === 1'b1) begin
        if (run_len == 0) begin
          for (int i = 0; i < 72; i++) cap[i] = 8'h00;
          if (n_runs < 16) rise_t[n_runs] = cyc;
        end
        if (run_len < 288) cap[run_len / 4][2 * (run_len % 4) +: 2] = txd_o;
        run_len++;
      end else if (run_len > 0) begin
        if (n_runs < 16) begin
          len_log[n_runs] = run_len;
          fcs_log[n_runs] = {cap[71], cap[70], cap[69], cap[68]};
        end
        if (run_len == 288) begin
          r = 32'hFFFFFFFF;
          for (int i = 8; i < 72; i++) r = crc_byte(r, cap[i]);
          check("frame_crc_residue", r, 32'hDEBB20E3);
          n_full++;
        end else begin
          n_trunc++;
        end
        n_runs++;
        run_len = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] d, input logic [15:0] a);
    @(posedge clk);
    #2 valid_i = 1'b1; data_i = d; addr_i = a;
    @(posedge clk);
    #2 valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0]  pin [72];
    logic [7:0]  ascii [9];
    logic [31:0] c;

    rst = 1'b1; valid_i = 1'b0; data_i = '0; addr_i = '0;

    // hand-computed pins on the model itself
    build_frame(16'hBEEF, 16'h0000, pin);
    check("pin_preamble0", {24'd0, pin[0]},  32'h55);
    check("pin_sfd",       {24'd0, pin[7]},  32'hD5);
    check("pin_dst0",      {24'd0, pin[8]},  32'hFF);
    check("pin_src0",      {24'd0, pin[14]}, 32'h69);
    check("pin_src5",      {24'd0, pin[19]}, 32'h91);
    check("pin_etype",     {16'd0, pin[20], pin[21]}, 32'h0002);
`ifdef ETHERNET_TX_ADDR_ECHO_EN
    check("pin_payload",   {pin[22], pin[23], pin[24], pin[25]}, 32'hBEEF0000 >> 16);
`else
    check("pin_payload",   {pin[22], pin[23], pin[24], pin[25]}, 32'hBEEF0000);
`endif
    check("pin_pad_last",  {24'd0, pin[67]}, 32'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 72; i++) c = crc_byte(c, pin[i]);
    check("pin_residue", c, 32'hDEBB20E3);
    for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_byte(c, ascii[i]);
    check("pin_crc_check_value", ~c, 32'hCBF43926);
    build_frame(16'h5678, 16'h1234, pin);
`ifdef ETHERNET_TX_ADDR_ECHO_EN
    check("pin_echo_payload", {pin[22], pin[23], pin[24], pin[25]}, 32'h12345678);
`else
    check("pin_echo_payload", {pin[22], pin[23], pin[24], pin[25]}, 32'h56780000);
`endif

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    // run0: single frame
    send(16'hBEEF, 16'h0000);
    repeat (400) @(posedge clk);

    // runs 1-3: valid held high
    @(posedge clk);
    #2 valid_i = 1'b1; data_i = 16'hA5A5;
    repeat (700) @(posedge clk);
    #2 valid_i = 1'b0;
    repeat (400) @(posedge clk);

    // run4 truncated by reset in BODY cycle 100, run5 follow-up
    send(16'hC0DE, 16'h0000);
    repeat (132) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    send(16'h1357, 16'h0000);
    repeat (400) @(posedge clk);

    // runs 6-7: 0000 then FFFF back-to-back
    @(posedge clk);
    #2 valid_i = 1'b1; data_i = 16'h0000;
    @(posedge clk);
    #2 data_i = 16'hFFFF;
    repeat (337) @(posedge clk);
    #2 valid_i = 1'b0;
    repeat (400) @(posedge clk);

    // run8: address/data pair
    send(16'h5678, 16'h1234);
    repeat (400) @(posedge clk);

    check("runs_total",     n_runs,  32'd9);
    check("full_frames",    n_full,  32'd8);
    check("trunc_frames",   n_trunc, 32'd1);
    check("run0_len",       len_log[0], 32'd288);
    check("run4_truncated", {31'd0, len_log[4] < 288}, 32'd1);
    check("spacing_1_2",    rise_t[2] - rise_t[1], 32'd337);
    check("spacing_2_3",    rise_t[3] - rise_t[2], 32'd337);
    check("fcs_differ_0000_ffff", {31'd0, fcs_log[6] != fcs_log[7]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
